// File: rtl/wb_shared_bus_rr.sv
// Shared Wishbone bus: round-robin arbitration among masters, address decode to slaves,
// an error response for unmapped addresses, and a watchdog that errors out stalled strobes.
module wb_shared_bus_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES = 4,
  parameter int DEC_W = 8,
  parameter logic [NUM_SLAVES*DEC_W-1:0] SLAVE_BASES = {8'h90, 8'h92, 8'h04, 8'h00},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*32-1:0] m_adr_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_SLAVES-1:0]     s_cyc_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  output logic [31:0]               s_adr_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [31:0]               s_dat_o,
  input  logic [NUM_SLAVES*32-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i,
  input  logic [NUM_SLAVES-1:0]     s_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int WDT_W = (TIMEOUT_CYCLES < 256) ? 8 : ((TIMEOUT_CYCLES < 65536) ? 16 : 32);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          gidx_q, gidx_d, last_q, last_d, pick;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [WDT_W-1:0]       wdt_q, wdt_d;
  logic                   err_q, err_d, timeout_q, timeout_d;
  logic                   pick_vld, granted, g_cyc, g_stb;
  logic                   sel_vld, sl_ack, sl_err, stall, expire;
  logic [SW-1:0]          sel_idx;

  // Round-robin search starting one past the last granted master
  always_comb begin
    int idx;
    idx = 0;
    pick_vld = 1'b0;
    pick = last_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!pick_vld && m_cyc_i[idx]) begin
        pick_vld = 1'b1;
        pick = GW'(idx);
      end
    end
  end

  assign granted = (state_q == GRANTED);
  assign g_cyc   = granted & m_cyc_i[gidx_q];
  assign g_stb   = granted & m_stb_i[gidx_q];
  assign s_adr_o = granted ? m_adr_i[gidx_q*32 +: 32] : 32'h0;
  assign s_sel_o = granted ? m_sel_i[gidx_q*4 +: 4] : 4'h0;
  assign s_we_o  = granted & m_we_i[gidx_q];
  assign s_dat_o = granted ? m_dat_i[gidx_q*32 +: 32] : 32'h0;

  // Downward scan so the lowest matching slave index wins
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (granted && (s_adr_o[31 -: DEC_W] == SLAVE_BASES[i*DEC_W +: DEC_W])) begin
        sel_vld = 1'b1;
        sel_idx = SW'(i);
      end
    end
  end

  assign sl_ack  = sel_vld & s_ack_i[sel_idx];
  assign sl_err  = sel_vld & s_err_i[sel_idx];
  assign stall   = g_stb & sel_vld & ~sl_ack & ~sl_err;
  assign expire  = (TIMEOUT_CYCLES != 0) && stall && (wdt_q == WDT_W'(TIMEOUT_CYCLES));
  assign m_dat_o = sel_vld ? s_dat_i[sel_idx*32 +: 32] : 32'h0;

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (sel_vld) begin
      s_cyc_o[sel_idx] = g_cyc;
      s_stb_o[sel_idx] = g_stb;
    end
    if (granted) begin
      m_ack_o[gidx_q] = g_stb & sl_ack;
      m_err_o[gidx_q] = g_stb & (sl_err | err_q | expire);
    end
  end

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANTED;
          gidx_d  = pick;
          last_d  = pick;
          grant_d = '0;
          grant_d[pick] = 1'b1;
        end
      end
      GRANTED: begin
        if (!m_cyc_i[gidx_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Unmapped strobe errors every other cycle while held; it never feeds the watchdog
    err_d     = g_stb & ~sel_vld & ~err_q;
    wdt_d     = (stall && !expire) ? wdt_q + 1'b1 : '0;
    timeout_d = expire;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      gidx_q    <= '0;
      last_q    <= GW'(NUM_MASTERS - 1);
      grant_q   <= '0;
      wdt_q     <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wdt_q     <= wdt_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule
